// File: rtl/conflict_filter_if.sv
// conflict_filter_if: AXI-Stream-style transaction channel.
//   tvalid / tready               : handshake
//   tdata_owner_programID         : 64-bit owner ID
//   tdata_read_dependencies       : read dependency bitmap
//   tdata_write_dependencies      : write dependency bitmap
// master drives valid/data and samples ready; slave is the mirror image.
interface conflict_filter_if #(
    parameter int unsigned MAX_DEPENDENCIES = 256
);
    logic                        tvalid;
    logic                        tready;
    logic [63:0]                 tdata_owner_programID;
    logic [MAX_DEPENDENCIES-1:0] tdata_read_dependencies;
    logic [MAX_DEPENDENCIES-1:0] tdata_write_dependencies;

    modport master (
        output tvalid,
        input  tready,
        output tdata_owner_programID,
        output tdata_read_dependencies,
        output tdata_write_dependencies
    );

    modport slave (
        input  tvalid,
        output tready,
        input  tdata_owner_programID,
        input  tdata_read_dependencies,
        input  tdata_write_dependencies
    );
endinterface

// File: rtl/conflict_filter.sv
// conflict_filter: admission stage in front of the batch collector. Holds one
// transaction at a time and forwards it only if it does not conflict with the
// read/write masks accumulated for the open batch (or the batch is full).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_axis (slave)      : incoming transactions from the scheduler
//   m_axis (master)     : admitted transactions to the batch collector
//   batch_completed     : one-cycle pulse, the open batch has been closed
//   acc_read_mask       : cumulative read mask of the open batch
//   acc_write_mask      : cumulative write mask of the open batch
//   admitted_count      : transactions admitted to the open batch
//   stalled             : a held transaction is waiting for batch completion
//   conflicts_detected  : running count of conflict/full stall events
module conflict_filter #(
    parameter int unsigned MAX_DEPENDENCIES = 256,
    parameter int unsigned MAX_BATCH_SIZE   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    conflict_filter_if.slave            s_axis,
    conflict_filter_if.master           m_axis,
    input  logic                        batch_completed,
    output logic [MAX_DEPENDENCIES-1:0] acc_read_mask,
    output logic [MAX_DEPENDENCIES-1:0] acc_write_mask,
    output logic [3:0]                  admitted_count,
    output logic                        stalled,
    output logic [31:0]                 conflicts_detected
);
    localparam logic [1:0] StAccept    = 2'd0;
    localparam logic [1:0] StEval      = 2'd1;
    localparam logic [1:0] StSend      = 2'd2;
    localparam logic [1:0] StWaitClear = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic                        s_tready_q, s_tready_d;
    logic                        m_tvalid_q, m_tvalid_d;
    logic [63:0]                 m_id_q, m_id_d;
    logic [MAX_DEPENDENCIES-1:0] m_rd_q, m_rd_d, m_wr_q, m_wr_d;
    logic [63:0]                 hold_id_q, hold_id_d;
    logic [MAX_DEPENDENCIES-1:0] hold_rd_q, hold_rd_d, hold_wr_q, hold_wr_d;
    logic [MAX_DEPENDENCIES-1:0] acc_rd_q, acc_rd_d, acc_wr_q, acc_wr_d;
    logic [3:0]                  count_q, count_d;
    logic                        stalled_q, stalled_d;
    logic [31:0]                 conflicts_q, conflicts_d;
    logic                        conflict, full;

    // Read-after-read is harmless; any overlap involving a write is not.
    assign conflict = |(hold_wr_q & (acc_rd_q | acc_wr_q)) | |(hold_rd_q & acc_wr_q);
    assign full     = (count_q == 4'(MAX_BATCH_SIZE));

    always_comb begin
        state_d     = state_q;
        s_tready_d  = s_tready_q;
        m_tvalid_d  = m_tvalid_q;
        m_id_d      = m_id_q;
        m_rd_d      = m_rd_q;
        m_wr_d      = m_wr_q;
        hold_id_d   = hold_id_q;
        hold_rd_d   = hold_rd_q;
        hold_wr_d   = hold_wr_q;
        acc_rd_d    = acc_rd_q;
        acc_wr_d    = acc_wr_q;
        count_d     = count_q;
        stalled_d   = stalled_q;
        conflicts_d = conflicts_q;

        unique case (state_q)
            StAccept: begin
                if (batch_completed) begin
                    acc_rd_d = '0;
                    acc_wr_d = '0;
                    count_d  = '0;
                end
                if (s_axis.tvalid && s_tready_q) begin
                    hold_id_d  = s_axis.tdata_owner_programID;
                    hold_rd_d  = s_axis.tdata_read_dependencies;
                    hold_wr_d  = s_axis.tdata_write_dependencies;
                    s_tready_d = 1'b0;
                    state_d    = StEval;
                end
            end
            StEval: begin
                if (batch_completed) begin
                    // Clear now, decide next cycle against the empty batch.
                    acc_rd_d = '0;
                    acc_wr_d = '0;
                    count_d  = '0;
                end else if (!conflict && !full) begin
                    acc_rd_d   = acc_rd_q | hold_rd_q;
                    acc_wr_d   = acc_wr_q | hold_wr_q;
                    count_d    = count_q + 4'd1;
                    m_id_d     = hold_id_q;
                    m_rd_d     = hold_rd_q;
                    m_wr_d     = hold_wr_q;
                    m_tvalid_d = 1'b1;
                    state_d    = StSend;
                end else begin
                    conflicts_d = conflicts_q + 32'd1;
                    stalled_d   = 1'b1;
                    state_d     = StWaitClear;
                end
            end
            StSend: begin
                // The pending output becomes the first member of the new batch.
                if (batch_completed) begin
                    acc_rd_d = m_rd_q;
                    acc_wr_d = m_wr_q;
                    count_d  = 4'd1;
                end
                if (m_axis.tready) begin
                    m_tvalid_d = 1'b0;
                    s_tready_d = 1'b1;
                    state_d    = StAccept;
                end
            end
            StWaitClear: begin
                if (batch_completed) begin
                    acc_rd_d  = '0;
                    acc_wr_d  = '0;
                    count_d   = '0;
                    stalled_d = 1'b0;
                    state_d   = StEval;
                end
            end
            default: state_d = StAccept;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAccept;
            s_tready_q  <= 1'b1;
            m_tvalid_q  <= 1'b0;
            m_id_q      <= '0;
            m_rd_q      <= '0;
            m_wr_q      <= '0;
            hold_id_q   <= '0;
            hold_rd_q   <= '0;
            hold_wr_q   <= '0;
            acc_rd_q    <= '0;
            acc_wr_q    <= '0;
            count_q     <= '0;
            stalled_q   <= 1'b0;
            conflicts_q <= '0;
        end else begin
            state_q     <= state_d;
            s_tready_q  <= s_tready_d;
            m_tvalid_q  <= m_tvalid_d;
            m_id_q      <= m_id_d;
            m_rd_q      <= m_rd_d;
            m_wr_q      <= m_wr_d;
            hold_id_q   <= hold_id_d;
            hold_rd_q   <= hold_rd_d;
            hold_wr_q   <= hold_wr_d;
            acc_rd_q    <= acc_rd_d;
            acc_wr_q    <= acc_wr_d;
            count_q     <= count_d;
            stalled_q   <= stalled_d;
            conflicts_q <= conflicts_d;
        end
    end

    assign s_axis.tready                   = s_tready_q;
    assign m_axis.tvalid                   = m_tvalid_q;
    assign m_axis.tdata_owner_programID    = m_id_q;
    assign m_axis.tdata_read_dependencies  = m_rd_q;
    assign m_axis.tdata_write_dependencies = m_wr_q;
    assign acc_read_mask                   = acc_rd_q;
    assign acc_write_mask                  = acc_wr_q;
    assign admitted_count                  = count_q;
    assign stalled                         = stalled_q;
    assign conflicts_detected              = conflicts_q;
endmodule

// File: tb/tb_conflict_filter.sv
// tb_conflict_filter: directed-vector bench for conflict_filter. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_conflict_filter;
    localparam int unsigned DEPS  = 256;
    localparam int unsigned BATCH = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            batch_completed;
    logic [DEPS-1:0] acc_read_mask, acc_write_mask;
    logic [3:0]      admitted_count;
    logic            stalled;
    logic [31:0]     conflicts_detected;

    conflict_filter_if #(.MAX_DEPENDENCIES(DEPS)) s_if ();
    conflict_filter_if #(.MAX_DEPENDENCIES(DEPS)) m_if ();

    conflict_filter #(
        .MAX_DEPENDENCIES (DEPS),
        .MAX_BATCH_SIZE   (BATCH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_axis             (s_if),
        .m_axis             (m_if),
        .batch_completed    (batch_completed),
        .acc_read_mask      (acc_read_mask),
        .acc_write_mask     (acc_write_mask),
        .admitted_count     (admitted_count),
        .stalled            (stalled),
        .conflicts_detected (conflicts_detected)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int xfers   = 0;

    // Downstream transfers, seen with pre-edge values.
    always @(posedge clk) begin
        if (m_if.tvalid && m_if.tready) xfers <= xfers + 1;
    end

    task automatic check(input string tag, input logic [DEPS-1:0] got,
                         input logic [DEPS-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DEPS-1:0] bit_at(input int i);
        logic [DEPS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        batch_completed = 1'b0;
        s_if.tvalid     = 1'b0;
        m_if.tready     = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_bc();
        batch_completed = 1'b1;
        @(negedge clk);
        batch_completed = 1'b0;
    endtask

    // Present one transaction; returns on the falling edge after the handshake.
    task automatic push(input logic [63:0] id, input logic [DEPS-1:0] r,
                        input logic [DEPS-1:0] w);
        int guard = 0;
        while (s_if.tready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("push_ready", s_if.tready, 1'b1);
        s_if.tvalid                   = 1'b1;
        s_if.tdata_owner_programID    = id;
        s_if.tdata_read_dependencies  = r;
        s_if.tdata_write_dependencies = w;
        @(negedge clk);
        s_if.tvalid = 1'b0;
    endtask

    // Push a transaction expected to pass, with m_axis ready held high.
    task automatic send_ok(input logic [63:0] id, input logic [DEPS-1:0] r,
                           input logic [DEPS-1:0] w);
        push(id, r, w);
        check("lat_t1_valid", m_if.tvalid, 1'b0);
        @(negedge clk);
        check("lat_t2_valid", m_if.tvalid, 1'b1);
        check("out_id", m_if.tdata_owner_programID, id);
        check("out_rd", m_if.tdata_read_dependencies, r);
        check("out_wr", m_if.tdata_write_dependencies, w);
        @(negedge clk);
        check("post_valid", m_if.tvalid, 1'b0);
        check("post_sready", s_if.tready, 1'b1);
    endtask

    initial begin
        int base;
        rst_n                         = 1'b0;
        batch_completed               = 1'b0;
        s_if.tvalid                   = 1'b0;
        s_if.tdata_owner_programID    = '0;
        s_if.tdata_read_dependencies  = '0;
        s_if.tdata_write_dependencies = '0;
        m_if.tready                   = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_sready", s_if.tready, 1'b1);
        check("rst_mvalid", m_if.tvalid, 1'b0);
        check("rst_mid", m_if.tdata_owner_programID, 0);
        check("rst_accr", acc_read_mask, 0);
        check("rst_accw", acc_write_mask, 0);
        check("rst_count", admitted_count, 0);
        check("rst_stalled", stalled, 1'b0);
        check("rst_conf", conflicts_detected, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two non-conflicting transactions with a read-read overlap
        base = xfers;
        send_ok(64'h11, bit_at(3), bit_at(5));
        send_ok(64'h12, bit_at(3), bit_at(7));
        check("t1_accr", acc_read_mask, 256'h8);
        check("t1_accw", acc_write_mask, 256'hA0);
        check("t1_count", admitted_count, 2);
        check("t1_conf", conflicts_detected, 0);
        check("t1_xfers", 256'(xfers - base), 2);

        // Write-then-read conflict stalls until batch completion
        do_reset();
        send_ok(64'h21, '0, bit_at(5));
        push(64'h22, bit_at(5), '0);
        @(negedge clk);
        repeat (3) begin
            check("t2_stalled", stalled, 1'b1);
            check("t2_conf", conflicts_detected, 1);
            check("t2_sready", s_if.tready, 1'b0);
            check("t2_mvalid", m_if.tvalid, 1'b0);
            @(negedge clk);
        end
        pulse_bc();
        check("t2_unstall", stalled, 1'b0);
        check("t2_mvalid_eval", m_if.tvalid, 1'b0);
        @(negedge clk);
        check("t2_fwd_valid", m_if.tvalid, 1'b1);
        check("t2_fwd_id", m_if.tdata_owner_programID, 64'h22);
        check("t2_accr", acc_read_mask, 256'h20);
        check("t2_accw", acc_write_mask, 0);
        check("t2_count", admitted_count, 1);
        @(negedge clk);

        // Batch full after eight admissions
        do_reset();
        for (int i = 0; i < 8; i++) send_ok(64'(100 + i), '0, bit_at(i));
        check("t3_count8", admitted_count, 8);
        check("t3_accw8", acc_write_mask, 256'hFF);
        push(64'd108, '0, bit_at(8));
        @(negedge clk);
        check("t3_stalled", stalled, 1'b1);
        check("t3_conf", conflicts_detected, 1);
        check("t3_count_hold", admitted_count, 8);
        check("t3_mvalid", m_if.tvalid, 1'b0);
        pulse_bc();
        @(negedge clk);
        check("t3_fwd_valid", m_if.tvalid, 1'b1);
        check("t3_fwd_id", m_if.tdata_owner_programID, 64'd108);
        check("t3_count1", admitted_count, 1);
        check("t3_accw", acc_write_mask, bit_at(8));
        @(negedge clk);

        // Downstream backpressure
        do_reset();
        m_if.tready = 1'b0;
        base        = xfers;
        push(64'h44, bit_at(2), bit_at(1));
        @(negedge clk);
        repeat (5) begin
            check("t4_mvalid", m_if.tvalid, 1'b1);
            check("t4_id", m_if.tdata_owner_programID, 64'h44);
            check("t4_wr", m_if.tdata_write_dependencies, bit_at(1));
            check("t4_sready", s_if.tready, 1'b0);
            @(negedge clk);
        end
        m_if.tready = 1'b1;
        @(negedge clk);
        check("t4_done_valid", m_if.tvalid, 1'b0);
        check("t4_sready_back", s_if.tready, 1'b1);
        check("t4_xfers", 256'(xfers - base), 1);

        // Batch completion while a transaction waits in SEND
        do_reset();
        send_ok(64'h50, '0, bit_at(2));
        m_if.tready = 1'b0;
        base        = xfers;
        push(64'h51, '0, bit_at(9));
        @(negedge clk);
        check("t5_mvalid", m_if.tvalid, 1'b1);
        check("t5_count_pre", admitted_count, 2);
        pulse_bc();
        check("t5_accw", acc_write_mask, 256'h200);
        check("t5_accr", acc_read_mask, 0);
        check("t5_count", admitted_count, 1);
        check("t5_mvalid_kept", m_if.tvalid, 1'b1);
        check("t5_id_kept", m_if.tdata_owner_programID, 64'h51);
        m_if.tready = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_xfers", 256'(xfers - base), 1);

        // Asynchronous reset during WAIT_CLEAR
        do_reset();
        send_ok(64'h61, '0, bit_at(5));
        push(64'h62, bit_at(5), '0);
        @(negedge clk);
        check("t6_pre_stalled", stalled, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_async_stalled", stalled, 1'b0);
        @(negedge clk);
        check("t6_mvalid", m_if.tvalid, 1'b0);
        check("t6_sready", s_if.tready, 1'b1);
        check("t6_accr", acc_read_mask, 0);
        check("t6_accw", acc_write_mask, 0);
        check("t6_stalled", stalled, 1'b0);
        check("t6_conf", conflicts_detected, 0);
        check("t6_count", admitted_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
